// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and synchronous flush. Define FIFO_FWFT_EN for a first-word-fall-through read port.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  rd_accept;
  logic                  wr_accept;

  // A full FIFO can still take a write when a read frees a slot on the same edge.
  assign rd_accept = rd_en && !empty && !flush;
  assign wr_accept = wr_en && (!full || rd_accept) && !flush;

  // NOTE: combinational logic assigns a default first so no path leaves a variable unassigned (no latch).
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({wr_accept, rd_accept})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count define what is valid,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
        if (rd_accept) rd_ptr <= rd_ptr + PW'(1);
      end
      count        <= count_next;
      full         <= (count_next == DEPTH_CNT);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_CNT);
      almost_empty <= (count_next <= AE_CNT);
      // Flush swallows pending requests silently, so it masks the error pulses.
      overflow     <= wr_en && !wr_accept && !flush;
      underflow    <= rd_en && !rd_accept && !flush;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry is always presented; it is meaningless while empty is high.
  assign data_out = mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_accept) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (default parameters); follows FIFO_FWFT_EN
// for the read latency it expects.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] last_rd;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given requests; when chk is set the read word is compared
  // at the point the active build presents it.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic chk, input logic [DW-1:0] exp);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
`ifdef FIFO_FWFT_EN
    if (chk) check("rd_data", {24'd0, data_out}, {24'd0, exp});
`endif
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
    if (chk) check("rd_data", {24'd0, data_out}, {24'd0, exp});
`endif
    if (chk) last_rd = exp;
  endtask

  task automatic check_flags(input string tag, input int cnt);
    check({tag, "_count"}, 32'(count), 32'(cnt));
    check({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, "_full"},  32'(full),  32'(cnt == DEPTH));
    check({tag, "_af"},    32'(almost_full),  32'(cnt >= DEPTH - 2));
    check({tag, "_ae"},    32'(almost_empty), 32'(cnt <= 2));
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_flags("rst", 0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_unf", 32'(underflow), 32'h0);

    // Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0, '0);
      if (i == 12 || i == 13 || i == 14 || i == 15) check_flags("fill", i + 1);
    end
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, '0);
    check("ovf_pulse", 32'(overflow), 32'h1);
    check("ovf_count", 32'(count), 32'd16);
    step();
    check("ovf_drop", 32'(overflow), 32'h0);

    // Drain in order, then one rejected read
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b1, DW'(i));
      if (i == 12 || i == 13 || i == 15) check_flags("drain", DEPTH - 1 - i);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    check("unf_pulse", 32'(underflow), 32'h1);
    check("unf_count", 32'(count), 32'd0);
`ifndef FIFO_FWFT_EN
    check("unf_data_hold", 32'(data_out), 32'h0F);
`endif
    step();
    check("unf_drop", 32'(underflow), 32'h0);

    // Simultaneous read and write at full
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0, '0);
    cyc(1'b1, 8'h55, 1'b1, 1'b1, 8'h80);
    check_flags("rw_full", DEPTH);
    check("rw_full_ovf", 32'(overflow), 32'h0);
    for (int i = 1; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b1, DW'(8'h80 + i));
    cyc(1'b0, '0, 1'b1, 1'b1, 8'h55);
    check_flags("rw_full_drained", 0);

    // Simultaneous read and write at empty
    cyc(1'b1, 8'h77, 1'b1, 1'b0, '0);
    check_flags("rw_empty", 1);
    check("rw_empty_unf", 32'(underflow), 32'h1);
    cyc(1'b0, '0, 1'b1, 1'b1, 8'h77);
    check_flags("rw_empty_drained", 0);

    // Wrap-around with occupancy held at 3
    for (int i = 0; i < 3; i++) begin
      model_q.push_back(DW'(8'hC0 + i));
      cyc(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] d;
      logic [DW-1:0] e;
      d = DW'($urandom);
      e = model_q.pop_front();
      model_q.push_back(d);
      cyc(1'b1, d, 1'b1, 1'b1, e);
      check("wrap_count", 32'(count), 32'd3);
      check("wrap_flags", {28'd0, full, empty, almost_full, almost_empty}, 32'h0);
      check("wrap_err", {30'd0, overflow, underflow}, 32'h0);
    end
    while (model_q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b1, model_q.pop_front());
    check_flags("wrap_end", 0);

    // Flush at count 9 together with a write
    for (int i = 0; i < 9; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, '0);
    check("pre_flush_count", 32'(count), 32'd9);
    flush = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, '0);
    flush = 1'b0;
    check_flags("flush", 0);
    check("flush_err", {30'd0, overflow, underflow}, 32'h0);
`ifndef FIFO_FWFT_EN
    check("flush_data_hold", 32'(data_out), 32'(last_rd));
`endif
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b1, 8'h3C);
    check_flags("post_flush", 0);

    // Asynchronous reset between edges during a burst
    cyc(1'b1, 8'h11, 1'b0, 1'b0, '0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b1, 8'h11);
    wr_en   = 1'b1;
    data_in = 8'h33;
    #3 rst_n = 1'b0;
    #1;
    check_flags("arst", 0);
    check("arst_err", {30'd0, overflow, underflow}, 32'h0);
`ifndef FIFO_FWFT_EN
    check("arst_data", 32'(data_out), 32'h0);
`endif
    wr_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check_flags("arst_release", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
